// File: rtl/returner.sv
// Return engine: drains pending write/read completions one per cycle.
// Writes take priority over reads, and the lowest pending index wins within each array.
module returner #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IDXW  = 6
) (
   input  logic        clk,
   input  logic        rst,
   output logic        wd,
   output logic        rd,
   output logic [31:0] data
);

   // Filled externally by hierarchical deposit; this block only clears entries.
   logic        write_return_array [0:DEPTH-1];
   logic [31:0] read_return_array  [0:DEPTH-1];

   logic            wr_any;
   logic [IDXW-1:0] wr_idx;
   logic            rd_any;
   logic [IDXW-1:0] rd_idx;

   logic        wd_q;
   logic        rd_q;
   logic [31:0] data_q;

   // Fixed-priority encoders: scanning downward leaves the lowest set index.
   always_comb begin
      wr_any = 1'b0;
      wr_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (write_return_array[i]) begin
            wr_any = 1'b1;
            wr_idx = IDXW'(i);
         end
      end
   end

   always_comb begin
      rd_any = 1'b0;
      rd_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (read_return_array[i][31]) begin
            rd_any = 1'b1;
            rd_idx = IDXW'(i);
         end
      end
   end

   // Only the winning entry is cleared, so entries deposited elsewhere survive the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_q   <= 1'b0;
         rd_q   <= 1'b0;
         data_q <= 32'h0;
         for (int i = 0; i < DEPTH; i++) begin
            write_return_array[i] <= 1'b0;
            read_return_array[i]  <= 32'h0;
         end
      end else if (wr_any) begin
         wd_q                       <= 1'b1;
         rd_q                       <= 1'b0;
         data_q                     <= {{(32 - IDXW){1'b0}}, wr_idx};
         write_return_array[wr_idx] <= 1'b0;
      end else if (rd_any) begin
         wd_q                          <= 1'b0;
         rd_q                          <= 1'b1;
         data_q                        <= {1'b0, read_return_array[rd_idx][30:0]};
         read_return_array[rd_idx][31] <= 1'b0;
      end else begin
         wd_q <= 1'b0;
         rd_q <= 1'b0;
      end
   end

   assign wd   = wd_q;
   assign rd   = rd_q;
   assign data = data_q;

endmodule

// File: tb/tb_returner.sv
// Directed bench for returner: deposits entries hierarchically and checks {wd, rd, data}.
module tb_returner;

   logic        clk;
   logic        rst;
   logic        wd;
   logic        rd;
   logic [31:0] data;

   int n_checks = 0;
   int n_errors = 0;

   returner dut (
      .clk  (clk),
      .rst  (rst),
      .wd   (wd),
      .rd   (rd),
      .data (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got wd=%0b rd=%0b data=%h, expected wd=%0b rd=%0b data=%h",
                  tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
      end
   endtask

   // Sample 1 ns after the rising edge; deposits made here land well before the next edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic dep_w(input int i);
      dut.write_return_array[i] = 1'b1;
   endtask

   task automatic dep_r(input int i, input logic [31:0] v);
      dut.read_return_array[i] = v;
   endtask

   initial begin
      rst = 1'b0;
      #3;
      check("reset_out", {wd, rd, data}, {2'b00, 32'h0});
      check("reset_arr", {33'h0, dut.write_return_array[0]}, 34'h0);

      // Scenario 1: idle after release
      tick;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         check("idle", {wd, rd, data}, {2'b00, 32'h0});
      end

      // Scenario 2: single write returns
      dep_w(0);
      tick;
      check("w0", {wd, rd, data}, {2'b10, 32'd0});
      tick;
      check("w0_done", {wd, rd, data}, {2'b00, 32'd0});
      dep_w(1);
      tick;
      check("w1", {wd, rd, data}, {2'b10, 32'd1});
      tick;
      check("w1_hold", {wd, rd, data}, {2'b00, 32'd1});

      // Scenario 3: separate, then together (lowest first)
      dep_w(4);
      tick;
      check("w4", {wd, rd, data}, {2'b10, 32'd4});
      dep_w(3);
      tick;
      check("w3", {wd, rd, data}, {2'b10, 32'd3});
      dep_w(4);
      dep_w(3);
      tick;
      check("pair_3", {wd, rd, data}, {2'b10, 32'd3});
      tick;
      check("pair_4", {wd, rd, data}, {2'b10, 32'd4});
      tick;
      check("pair_idle", {wd, rd, data}, {2'b00, 32'd4});

      // Scenario 4: write beats read
      dep_r(2, 32'h8000_1234);
      dep_w(5);
      tick;
      check("prio_w5", {wd, rd, data}, {2'b10, 32'd5});
      tick;
      check("prio_r2", {wd, rd, data}, {2'b01, 32'h0000_1234});
      tick;
      check("prio_idle", {wd, rd, data}, {2'b00, 32'h0000_1234});
      check("r2_cleared", {2'b00, dut.read_return_array[2]}, {2'b00, 32'h0000_1234});

      // Read ordering and the valid bit
      dep_r(1, 32'h0000_5555);
      dep_r(6, 32'h8000_0006);
      dep_r(3, 32'hFFFF_FFAB);
      tick;
      check("r3", {wd, rd, data}, {2'b01, 32'h7FFF_FFAB});
      tick;
      check("r6", {wd, rd, data}, {2'b01, 32'h0000_0006});
      tick;
      check("r_invalid", {wd, rd, data}, {2'b00, 32'h0000_0006});

      // Scenario 6: deposit at another index survives the clear
      dep_w(7);
      dep_w(9);
      tick;
      check("w7", {wd, rd, data}, {2'b10, 32'd7});
      check("w9_kept", {33'h0, dut.write_return_array[9]}, 34'h1);
      tick;
      check("w9", {wd, rd, data}, {2'b10, 32'd9});
      tick;
      check("w9_idle", {wd, rd, data}, {2'b00, 32'd9});

      // Scenario 5: full drain interrupted by reset
      for (int i = 0; i < 64; i++) dep_w(i);
      for (int i = 0; i < 10; i++) begin
         tick;
         check($sformatf("drain_%0d", i), {wd, rd, data}, {2'b10, 32'(i)});
      end
      rst = 1'b0;
      #1;
      check("midrst_out", {wd, rd, data}, {2'b00, 32'h0});
      check("midrst_arr", {33'h0, dut.write_return_array[10]}, 34'h0);
      tick;
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick;
         check("post_rst", {wd, rd, data}, {2'b00, 32'h0});
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/returner.md
RETURNER -- requirements
Module: returner

Interface
REQ-001 Parameter DEPTH, default 64: number of return slots in each return array.
REQ-002 Parameter IDXW, default 6: width of a slot index, equal to log2(DEPTH).
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port wd, output, 1 bit: write-done strobe, high for exactly one cycle per returned write slot.
REQ-006 Port rd, output, 1 bit: read-done strobe, high for exactly one cycle per returned read slot.
REQ-007 Port data, output, 32 bits: payload of the current return; qualified by wd or rd.
REQ-008 Port order for positional instantiation SHALL be: clk, rst, wd, rd, data.

Function
REQ-009 Internal register write_return_array[0:DEPTH-1] SHALL hold 1 bit per slot; 1 = write completion pending.
REQ-010 Internal register read_return_array[0:DEPTH-1] SHALL hold 32 bits per slot: bit 31 = valid, bits 30:0 = read address.
REQ-011 Both arrays SHALL be writable by hierarchical deposit (bench, or future fill logic) at any time; the block itself only clears entries.
REQ-012 On each rising clk edge, the block SHALL select at most one pending entry, from either array, to return.
REQ-013 Write returns SHALL have priority over read returns; a read is returned only when no write bit is set.
REQ-014 Within an array, the lowest pending index SHALL win (fixed priority, no round-robin).
REQ-015 Write return, winning index i: at that edge wd<=1, rd<=0, data<={zeros, i[IDXW-1:0]}, and write_return_array[i]<=0.
REQ-016 Read return, winning index j: at that edge rd<=1, wd<=0, data<={1'b0, read_return_array[j][30:0]}, and read_return_array[j][31]<=0.
REQ-017 When nothing is pending: wd<=0, rd<=0, and data SHALL hold its previous value.
REQ-018 wd and rd SHALL never be high in the same cycle.
REQ-019 Latency: an entry deposited before edge N (and winning priority) SHALL produce its strobe and data in the cycle following edge N.
REQ-020 Clearing SHALL be per entry; only the returned entry is cleared, and entries deposited in the same cycle at other indices SHALL be preserved.
REQ-021 Throughput: one return per cycle; K pending entries SHALL drain in exactly K consecutive strobe cycles.
REQ-022 Outputs SHALL be registered, with no combinational path from array contents to the ports.
REQ-023 Expected size is roughly 150-250 lines: two DEPTH-wide priority encoders, a 32-bit output mux, and clear logic.

Reset
REQ-024 While rst=0: wd=0, rd=0, data=32'h0, all write_return_array bits=0, and all read_return_array entries=0, asynchronously.
REQ-025 Deassertion of rst SHALL take effect at the next rising clk edge; returns may begin on that edge.
REQ-026 Reset asserted mid-drain SHALL discard all pending entries immediately; nothing is returned after release.

Verification
REQ-027 Scenario 1: rst low then high, nothing deposited -> wd=rd=0 and data=0 indefinitely.
REQ-028 Scenario 2: deposit write_return_array[0]=1 -> one-cycle wd pulse with data=0; then write_return_array[1]=1 -> one-cycle wd pulse with data=1.
REQ-029 Scenario 3: deposit write_return_array[4]=1, then write_return_array[3]=1 on a later cycle -> wd pulses with data=4, then data=3; with both pending together -> data=3 then data=4 on consecutive cycles.
REQ-030 Scenario 4: deposit read_return_array[2]=32'h8000_1234 and write_return_array[5]=1 in the same cycle -> wd with data=5, next cycle rd with data=32'h0000_1234, then both strobes low.
REQ-031 Scenario 5: deposit write bits 0..63 all set, pulse rst low after 10 returns -> outputs 0 immediately, no further strobes after release.
REQ-032 Scenario 6: with index 7 being returned, deposit index 9 in the same cycle -> index 9 retained and returned next cycle with data=9.
